// File: rtl/fcl_mac_acc.sv
// fcl_mac_acc: multiply-accumulate front end of fully-connected layer 1.
// Accumulates NUM_TAPS act*wgt products per neuron, then saturates to ACC_WIDTH.
// Optional feature macro FCL_MAC_BIAS_EN: adds the fcl_bias_i port and a
// per-neuron bias add before saturation. Latency is the same in both builds.
module fcl_mac_acc #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned NUM_NEURONS  = 4,
    parameter int unsigned NUM_TAPS     = 120,
    parameter int unsigned ACC_WIDTH    = 22
) (
    input  logic                                    fcl_clk,
    input  logic                                    fcl_rst,
    input  logic                                    fcl_start_i,
    input  logic                                    fcl_in_valid_i,
    output logic                                    fcl_in_ready_o,
    input  logic [DATA_WIDTH-1:0]                   fcl_act_i,
    input  logic [NUM_NEURONS-1:0][WEIGHT_WIDTH-1:0] fcl_wgt_i,
`ifdef FCL_MAC_BIAS_EN
    input  logic [NUM_NEURONS-1:0][ACC_WIDTH-1:0]   fcl_bias_i,
`endif
    output logic                                    fcl_out_valid_o,
    input  logic                                    fcl_out_ready_i,
    output logic [NUM_NEURONS-1:0][ACC_WIDTH-1:0]   fcl_out_o,
    output logic                                    fcl_busy_o
);

    localparam int unsigned PROD_W    = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int unsigned ACC_INT_W = PROD_W + $clog2(NUM_TAPS) + 1;
    localparam int unsigned SUM_W     = ((ACC_INT_W > ACC_WIDTH) ? ACC_INT_W : ACC_WIDTH) + 1;
    localparam int unsigned CNT_W     = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TAPS - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_FINAL,
        S_OUT
    } state_e;

    state_e                                  state_q, state_d;
    logic [CNT_W-1:0]                        cnt_q, cnt_d;
    logic                                    prod_vld_q, prod_vld_d;
    logic signed [PROD_W-1:0]                prod_q [NUM_NEURONS];
    logic signed [PROD_W-1:0]                prod_d [NUM_NEURONS];
    logic signed [ACC_INT_W-1:0]             acc_q  [NUM_NEURONS];
    logic signed [ACC_INT_W-1:0]             acc_d  [NUM_NEURONS];
    logic [NUM_NEURONS-1:0][ACC_WIDTH-1:0]   out_q, out_d;
    logic                                    out_valid_q, out_valid_d;
    logic                                    in_ready_q, in_ready_d;
    logic                                    busy_q, busy_d;

    logic signed [PROD_W-1:0]                act_ext_c;
    logic signed [SUM_W-1:0]                 sum_c;
    logic [NUM_NEURONS-1:0][ACC_WIDTH-1:0]   sat_c;

    function automatic logic [ACC_WIDTH-1:0] sat_f(input logic signed [SUM_W-1:0] s);
        logic [ACC_WIDTH-1:0] r;
        if (s > SAT_MAX) begin
            r = SAT_MAX[ACC_WIDTH-1:0];
        end else if (s < SAT_MIN) begin
            r = SAT_MIN[ACC_WIDTH-1:0];
        end else begin
            r = s[ACC_WIDTH-1:0];
        end
        return r;
    endfunction

    // Widened (optionally biased) sum per neuron, clamped to the output range.
    always_comb begin
        sum_c = '0;
        sat_c = '0;
        for (int k = 0; k < int'(NUM_NEURONS); k++) begin
`ifdef FCL_MAC_BIAS_EN
            sum_c = SUM_W'(acc_q[k]) + SUM_W'($signed(fcl_bias_i[k]));
`else
            sum_c = SUM_W'(acc_q[k]);
`endif
            sat_c[k] = sat_f(sum_c);
        end
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prod_vld_d  = 1'b0;
        prod_d      = prod_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        act_ext_c   = PROD_W'($signed(fcl_act_i));

        // A product registered on the previous edge is folded in now.
        if (prod_vld_q) begin
            for (int k = 0; k < int'(NUM_NEURONS); k++) begin
                acc_d[k] = acc_q[k] + ACC_INT_W'(prod_q[k]);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (fcl_start_i) begin
                    state_d = S_ACCUM;
                    cnt_d   = '0;
                    for (int k = 0; k < int'(NUM_NEURONS); k++) begin
                        acc_d[k] = '0;
                    end
                end
            end
            S_ACCUM: begin
                if (fcl_in_valid_i && in_ready_q) begin
                    prod_vld_d = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    for (int k = 0; k < int'(NUM_NEURONS); k++) begin
                        prod_d[k] = act_ext_c * PROD_W'($signed(fcl_wgt_i[k]));
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_FINAL;
            end
            S_FINAL: begin
                out_d       = sat_c;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (fcl_out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_ACCUM);
        busy_d     = (state_d != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge fcl_clk or posedge fcl_rst) begin
        if (fcl_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prod_vld_q  <= 1'b0;
            for (int k = 0; k < int'(NUM_NEURONS); k++) begin
                prod_q[k] <= '0;
                acc_q[k]  <= '0;
            end
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prod_vld_q  <= prod_vld_d;
            for (int k = 0; k < int'(NUM_NEURONS); k++) begin
                prod_q[k] <= prod_d[k];
                acc_q[k]  <= acc_d[k];
            end
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign fcl_in_ready_o  = in_ready_q;
    assign fcl_out_valid_o = out_valid_q;
    assign fcl_out_o       = out_q;
    assign fcl_busy_o      = busy_q;

endmodule

// File: tb/tb_fcl_mac_acc.sv
// tb_fcl_mac_acc: directed bench for fcl_mac_acc using three instances
// (NUM_TAPS = 4, 120 and 200) that share stimulus; sel picks the active one.
module tb_fcl_mac_acc;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  valid;
    logic [7:0]            act;
    logic [3:0][7:0]       wgt;
    logic                  out_ready;
`ifdef FCL_MAC_BIAS_EN
    logic [3:0][21:0]      bias;
`endif

    int                    sel;
    logic                  st [3];
    logic                  ir [3];
    logic                  ov [3];
    logic                  bz [3];
    logic [3:0][21:0]      ob [3];

    int checks;
    int failures;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            st[i] = start && (sel == i);
        end
    end

    fcl_mac_acc #(.NUM_TAPS(4)) u_dut_t4 (
        .fcl_clk(clk), .fcl_rst(rst), .fcl_start_i(st[0]),
        .fcl_in_valid_i(valid), .fcl_in_ready_o(ir[0]),
        .fcl_act_i(act), .fcl_wgt_i(wgt),
`ifdef FCL_MAC_BIAS_EN
        .fcl_bias_i(bias),
`endif
        .fcl_out_valid_o(ov[0]), .fcl_out_ready_i(out_ready),
        .fcl_out_o(ob[0]), .fcl_busy_o(bz[0])
    );

    fcl_mac_acc u_dut_t120 (
        .fcl_clk(clk), .fcl_rst(rst), .fcl_start_i(st[1]),
        .fcl_in_valid_i(valid), .fcl_in_ready_o(ir[1]),
        .fcl_act_i(act), .fcl_wgt_i(wgt),
`ifdef FCL_MAC_BIAS_EN
        .fcl_bias_i(bias),
`endif
        .fcl_out_valid_o(ov[1]), .fcl_out_ready_i(out_ready),
        .fcl_out_o(ob[1]), .fcl_busy_o(bz[1])
    );

    fcl_mac_acc #(.NUM_TAPS(200)) u_dut_t200 (
        .fcl_clk(clk), .fcl_rst(rst), .fcl_start_i(st[2]),
        .fcl_in_valid_i(valid), .fcl_in_ready_o(ir[2]),
        .fcl_act_i(act), .fcl_wgt_i(wgt),
`ifdef FCL_MAC_BIAS_EN
        .fcl_bias_i(bias),
`endif
        .fcl_out_valid_o(ov[2]), .fcl_out_ready_i(out_ready),
        .fcl_out_o(ob[2]), .fcl_busy_o(bz[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present beats until `taps` handshakes have occurred; gaps toggles valid.
    task automatic feed(input int taps, input logic [7:0] a, input logic [3:0][7:0] w,
                        input bit gaps);
        int  n_acc = 0;
        int  cyc   = 0;
        bit  ph    = 1'b1;
        bit  hs;
        act = a;
        wgt = w;
        while (n_acc < taps && cyc < 1000) begin
            valid = gaps ? ph : 1'b1;
            ph    = !ph;
            hs    = valid && ir[sel];
            tick();
            cyc++;
            if (hs) n_acc++;
        end
        valid = 1'b0;
        checks++;
        if (n_acc != taps) begin
            failures++;
            $display("FAIL feed_accepts got=%0d want=%0d", n_acc, taps);
        end
    endtask

    task automatic wait_out();
        int n = 0;
        while (!ov[sel] && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (!ov[sel]) begin
            failures++;
            $display("FAIL out_valid_timeout sel=%0d", sel);
        end
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic logic [3:0][21:0] all_same(input logic [21:0] v);
        logic [3:0][21:0] r;
        for (int k = 0; k < 4; k++) r[k] = v;
        return r;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            checks += 4;
            if (ir[i] !== 1'b0) begin failures++; $display("FAIL rst_in_ready dut=%0d got=%b want=0", i, ir[i]); end
            if (ov[i] !== 1'b0) begin failures++; $display("FAIL rst_out_valid dut=%0d got=%b want=0", i, ov[i]); end
            if (bz[i] !== 1'b0) begin failures++; $display("FAIL rst_busy dut=%0d got=%b want=0", i, bz[i]); end
            if (ob[i] !== '0)   begin failures++; $display("FAIL rst_out dut=%0d got=%h want=0", i, ob[i]); end
        end
    endtask

    // Run a 4-tap vector, checking exact latency; out_ready pre-set when early_ready.
    task automatic run_basic(input string tag, input bit gaps, input bit early_ready);
        logic [3:0][7:0]  w;
        logic [3:0][21:0] exp;
        for (int k = 0; k < 4; k++) begin
            w[k]   = 8'(k + 1);
            exp[k] = 22'(4 * (k + 1));
        end
        sel       = 0;
        out_ready = early_ready;
        pulse_start();
        checks += 2;
        if (bz[0] !== 1'b1) begin failures++; $display("FAIL %s_busy_after_start got=%b want=1", tag, bz[0]); end
        if (ir[0] !== 1'b1) begin failures++; $display("FAIL %s_ready_after_start got=%b want=1", tag, ir[0]); end
        feed(4, 8'd1, w, gaps);
        checks += 2;
        if (ov[0] !== 1'b0) begin failures++; $display("FAIL %s_valid_L got=%b want=0", tag, ov[0]); end
        if (ir[0] !== 1'b0) begin failures++; $display("FAIL %s_ready_drop got=%b want=0", tag, ir[0]); end
        tick();
        checks++;
        if (ov[0] !== 1'b0) begin failures++; $display("FAIL %s_valid_L1 got=%b want=0", tag, ov[0]); end
        tick();
        checks += 2;
        if (ov[0] !== 1'b1) begin failures++; $display("FAIL %s_valid_L2 got=%b want=1", tag, ov[0]); end
        if (ob[0] !== exp)  begin failures++; $display("FAIL %s_sum got=%h want=%h", tag, ob[0], exp); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks += 3;
        if (ov[0] !== 1'b0) begin failures++; $display("FAIL %s_valid_clr got=%b want=0", tag, ov[0]); end
        if (bz[0] !== 1'b0) begin failures++; $display("FAIL %s_idle got=%b want=0", tag, bz[0]); end
        if (ob[0] !== exp)  begin failures++; $display("FAIL %s_out_hold got=%h want=%h", tag, ob[0], exp); end
    endtask

    task automatic test_basic();
        run_basic("basic", 1'b0, 1'b1);
    endtask

    task automatic test_stalls();
        run_basic("stall", 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [3:0][7:0]  w;
        logic [3:0][21:0] exp;
        for (int k = 0; k < 4; k++) begin
            w[k]   = 8'(k + 1);
            exp[k] = 22'(-4 * (k + 1));
        end
        sel       = 0;
        out_ready = 1'b0;
        pulse_start();
        feed(4, 8'hFF, w, 1'b0);
        wait_out();
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            checks += 4;
            if (ov[0] !== 1'b1) begin failures++; $display("FAIL bp_valid c=%0d got=%b want=1", c, ov[0]); end
            if (ir[0] !== 1'b0) begin failures++; $display("FAIL bp_in_ready c=%0d got=%b want=0", c, ir[0]); end
            if (bz[0] !== 1'b1) begin failures++; $display("FAIL bp_busy c=%0d got=%b want=1", c, bz[0]); end
            if (ob[0] !== exp)  begin failures++; $display("FAIL bp_out c=%0d got=%h want=%h", c, ob[0], exp); end
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks += 2;
        if (ov[0] !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b want=0", ov[0]); end
        if (bz[0] !== 1'b0) begin failures++; $display("FAIL bp_release_busy got=%b want=0", bz[0]); end
        tick();
        checks++;
        if (bz[0] !== 1'b0) begin failures++; $display("FAIL bp_start_ignored got=%b want=0", bz[0]); end
    endtask

    task automatic test_negative();
        sel = 1;
        pulse_start();
        feed(120, 8'h80, {4{8'h7F}}, 1'b0);
        wait_out();
        checks++;
        if (ob[1] !== all_same(22'h223C00)) begin
            failures++; $display("FAIL neg_sum got=%h want=%h", ob[1], all_same(22'h223C00));
        end
        finish_out();
    endtask

    task automatic test_saturation();
        sel = 2;
        pulse_start();
        feed(200, 8'h7F, {4{8'h7F}}, 1'b0);
        wait_out();
        checks++;
        if (ob[2] !== all_same(22'h1FFFFF)) begin
            failures++; $display("FAIL sat_pos got=%h want=%h", ob[2], all_same(22'h1FFFFF));
        end
        finish_out();
        pulse_start();
        feed(200, 8'h80, {4{8'h7F}}, 1'b0);
        wait_out();
        checks++;
        if (ob[2] !== all_same(22'h200000)) begin
            failures++; $display("FAIL sat_neg got=%h want=%h", ob[2], all_same(22'h200000));
        end
        finish_out();
    endtask

`ifdef FCL_MAC_BIAS_EN
    task automatic test_bias();
        sel  = 1;
        bias = all_same(22'h100000);
        pulse_start();
        feed(120, 8'h7F, {4{8'h7F}}, 1'b0);
        wait_out();
        checks++;
        if (ob[1] !== all_same(22'h1FFFFF)) begin
            failures++; $display("FAIL bias_sat got=%h want=%h", ob[1], all_same(22'h1FFFFF));
        end
        finish_out();
        bias = '0;
    endtask
`endif

    task automatic test_reset_mid();
        logic [3:0][7:0] w;
        for (int k = 0; k < 4; k++) w[k] = 8'(k + 1);
        sel = 0;
        pulse_start();
        feed(2, 8'd1, w, 1'b0);
        rst = 1'b1;
        #1;
        checks += 4;
        if (ir[0] !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b want=0", ir[0]); end
        if (ov[0] !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", ov[0]); end
        if (bz[0] !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", bz[0]); end
        if (ob[0] !== '0)   begin failures++; $display("FAIL midrst_out got=%h want=0", ob[0]); end
        tick();
        rst = 1'b0;
        tick();
        run_basic("after_rst", 1'b0, 1'b0);
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        valid     = 1'b0;
        act       = '0;
        wgt       = '0;
        out_ready = 1'b0;
        sel       = 0;
        checks    = 0;
        failures  = 0;
`ifdef FCL_MAC_BIAS_EN
        bias      = '0;
`endif
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_stalls();
        test_backpressure();
        test_negative();
        test_saturation();
`ifdef FCL_MAC_BIAS_EN
        test_bias();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fcl_mac_acc.md
# fcl_mac_acc

Multiply-accumulate front end of fully-connected layer 1. It consumes one signed activation per handshake beat together with one weight per neuron, and accumulates NUM_TAPS products for NUM_NEURONS neurons in parallel. It optionally adds a per-neuron bias, saturates each sum to ACC_WIDTH, and presents the packed result to the downstream ReLU activation stage (actv_relu, 22-bit × 4 inputs).

## Interface
- DATA_WIDTH, 8: signed activation width.
- WEIGHT_WIDTH, 8: signed weight width.
- NUM_NEURONS, 4: parallel neurons; equals the ReLU NUM_INPUTS.
- NUM_TAPS, 120: products per neuron per vector, 1..255.
- ACC_WIDTH, 22: signed output width; equals the ReLU INPUT_WIDTH.

- fcl_clk  in  1  clock; all state on rising edge.
- fcl_rst  in  1  asynchronous, active-high reset.
- fcl_start_i  in  1  pulse; starts a vector; honoured only in IDLE.
- fcl_in_valid_i  in  1  activation/weight beat valid.
- fcl_in_ready_o  out  1  beat accepted when valid & ready.
- fcl_act_i  in  DATA_WIDTH  signed activation.
- fcl_wgt_i  in  [NUM_NEURONS-1:0][WEIGHT_WIDTH-1:0]  signed weights, one per neuron.
- fcl_bias_i  in  [NUM_NEURONS-1:0][ACC_WIDTH-1:0]  signed biases; present only with FCL_MAC_BIAS_EN.
- fcl_out_valid_o  out  1  result valid.
- fcl_out_ready_i  in  1  downstream accepts result.
- fcl_out_o  out  [NUM_NEURONS-1:0][ACC_WIDTH-1:0]  signed saturated sums.
- fcl_busy_o  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCUM, DRAIN, FINAL, OUT.
- IDLE: in_ready=0. On start, clear the accumulators, tap counter and product-valid flag, then go to ACCUM.
- ACCUM: in_ready=1. Each accepted beat registers NUM_NEURONS products act×wgt[k] (signed, DATA_WIDTH+WEIGHT_WIDTH bits) and sets the product-valid flag.
  - A registered product is added to its accumulator on the next edge.
  - The counter increments per accepted beat.
  - On acceptance of beat NUM_TAPS, go to DRAIN; in_ready drops in the same edge.
- DRAIN: one cycle; the last product is added. Go to FINAL.
- FINAL: load each output register with sat(acc[k] (+ bias[k])). Set out_valid=1 and go to OUT.
- OUT: hold fcl_out_o and out_valid until out_ready=1. On the handshake edge, clear out_valid and go to IDLE. fcl_out_o retains its last value.
- Internal accumulator width: DATA_WIDTH+WEIGHT_WIDTH+$clog2(NUM_TAPS)+1. This cannot overflow. Bias is sign-extended before the add.
- Saturation limits: max 2^(ACC_WIDTH-1)-1 (22'h1FFFFF), min -2^(ACC_WIDTH-1) (22'h200000).
- Start outside IDLE is ignored. in_valid outside ACCUM is ignored.
- Gaps: in_valid low in ACCUM stalls the counter. Pending products still add. No beat is lost.

## Timing
- Reset: state=IDLE; fcl_in_ready_o=0, fcl_out_valid_o=0, fcl_busy_o=0, fcl_out_o=0. Accumulators, product registers and counter are 0.
- Start sampled at edge E: busy and in_ready are high after E. The first beat can be accepted at E+1.
- Last beat accepted at edge L: DRAIN after L, FINAL after L+1. out_valid is high after L+2.
- Minimum vector time: NUM_TAPS+3 cycles from start to out_valid, plus 1 cycle in OUT, plus 1 cycle back in IDLE.
- If out_ready is already high when out_valid rises, the handshake completes on the next edge.
- Reset asserted mid-operation aborts immediately to reset values. No partial result is emitted.

## Configuration
- FCL_MAC_BIAS_EN defined: the fcl_bias_i port exists, and the FINAL state adds the bias before saturation.
- FCL_MAC_BIAS_EN undefined: the port is absent, no adder is built, and FINAL saturates the raw accumulator.
- Latency is identical in both builds.

## Test plan
- Basic sum: NUM_TAPS=4, act=1 on all beats, wgt[k]=k+1, bias 0. Expect fcl_out_o = {16,12,8,4} ([3]..[0]), with out_valid exactly 2 edges after the 4th accept.
- Negative sum: default NUM_TAPS=120, act=-128, wgt=127 for all neurons. Expect each output = -1,950,720 (22'h223C00) and no saturation.
- Saturation: NUM_TAPS=200, act=127, wgt=127 gives 22'h1FFFFF. act=-128, wgt=127 gives 22'h200000. With FCL_MAC_BIAS_EN: NUM_TAPS=120, act=127, wgt=127, bias=2^20 gives 22'h1FFFFF.
- Stalls: the basic-sum vector with in_valid toggling every other cycle gives the same {16,12,8,4}. The counter advances only on handshakes.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid and pulse start meanwhile. Outputs stay stable, in_ready=0, start is ignored. Raising out_ready moves to IDLE in 1 edge.
- Reset mid-ACCUM: assert fcl_rst after 2 of 4 beats. All outputs read 0 immediately. A fresh start then yields {16,12,8,4}.
